axis_uart_tx_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares one AXI-Stream byte path between NUM_SRC independent AXI-Stream requesters.
- Sits upstream of the AXI-Stream FIFO/UART transmitter. Its master port drives the FIFO slave port (data/valid/ready/last).
- A grant is held for a whole packet, from first beat through the beat with last=1, so packets from different sources never interleave on the serial line.
- A stall watchdog releases a source that stops presenting data mid-packet.

---
 rtl/axis_arb_pkg.sv | 17 +
 rtl/axis_uart_tx_arbiter_rr_pick.sv | 28 ++
 rtl/axis_uart_tx_arbiter.sv | 114 +++++++++++
 tb/tb_axis_uart_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the packet-level AXI-Stream round-robin arbiter.
package axis_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    XFER = 2'd2
  } arb_state_t;

  localparam logic [7:0] TAG_BASE = 8'hA0;

  // Index width for NUM_SRC requesters, never narrower than one bit.
  function automatic int grant_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_uart_tx_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first asserted request at or after ptr, wrapping.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int GW      = grant_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic [GW-1:0]      gnt_idx,
  output logic               any_req
);

  assign any_req = |req;

  // Walk offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    logic [GW:0] w_sum;
    w_sum   = '0;
    gnt_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      w_sum = {1'b0, ptr} + (GW + 1)'(k);
      if (w_sum >= (GW + 1)'(NUM_SRC)) w_sum = w_sum - (GW + 1)'(NUM_SRC);
      if (req[w_sum[GW-1:0]]) gnt_idx = w_sum[GW-1:0];
    end
  end

endmodule

// File: rtl/axis_uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding one AXI-Stream byte path, with stall watchdog.
// Optional source-tag header beat enabled by defining AXIS_ARB_SRC_TAG_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate among valid sources
// TAG   | emit header beat TAG_BASE|grant_id (AXIS_ARB_SRC_TAG_EN only)
// XFER  | pass granted source through until last beat or watchdog release
module axis_uart_tx_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int NUM_SRC = 4,
  parameter  int TIMEOUT = 1024,
  localparam int GW      = grant_w(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*WIDTH-1:0] s_axis_data,
  input  logic [NUM_SRC-1:0]       s_axis_valid,
  input  logic [NUM_SRC-1:0]       s_axis_last,
  output logic [NUM_SRC-1:0]       s_axis_ready,
  output logic [WIDTH-1:0]         m_axis_data,
  output logic                     m_axis_valid,
  output logic                     m_axis_last,
  input  logic                     m_axis_ready,
  output logic [GW-1:0]            grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int CW = $clog2(TIMEOUT);

  arb_state_t       r_state, w_next;
  logic [GW-1:0]    r_grant, r_rr_ptr, w_pick;
  logic             w_any;
  logic [CW-1:0]    r_stall;
  logic             r_timeout_err, w_force;
  logic             w_gnt_valid, w_gnt_last;
  logic [WIDTH-1:0] w_gnt_data;

  rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req     (s_axis_valid),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_pick),
    .any_req (w_any)
  );

  assign w_gnt_valid = s_axis_valid[r_grant];
  assign w_gnt_last  = s_axis_last[r_grant];
  assign w_gnt_data  = s_axis_data[int'(r_grant)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_stall       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_timeout_err <= w_force;
      if (r_state == IDLE && w_any) begin
        r_grant  <= w_pick;
        r_rr_ptr <= (w_pick == GW'(NUM_SRC - 1)) ? '0 : w_pick + 1'b1;
      end
      // Only a missing beat from the owner counts; backpressure never does.
      if (r_state == XFER && w_next == XFER && !w_gnt_valid) r_stall <= r_stall + 1'b1;
      else r_stall <= '0;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_force      = 1'b0;
    m_axis_data  = '0;
    m_axis_valid = 1'b0;
    m_axis_last  = 1'b0;
    s_axis_ready = '0;
    case (r_state)
      IDLE: begin
`ifdef AXIS_ARB_SRC_TAG_EN
        if (w_any) w_next = TAG;
`else
        if (w_any) w_next = XFER;
`endif
      end
`ifdef AXIS_ARB_SRC_TAG_EN
      TAG: begin
        m_axis_data  = WIDTH'(TAG_BASE) | WIDTH'(r_grant);
        m_axis_valid = 1'b1;
        if (m_axis_ready) w_next = XFER;
      end
`endif
      XFER: begin
        m_axis_data           = w_gnt_data;
        m_axis_valid          = w_gnt_valid;
        m_axis_last           = w_gnt_last;
        s_axis_ready[r_grant] = m_axis_ready;
        if (w_gnt_valid && m_axis_ready && w_gnt_last) begin
          w_next = IDLE;
        end else if (!w_gnt_valid && r_stall == CW'(TIMEOUT - 1)) begin
          w_next  = IDLE;
          w_force = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign grant_id    = r_grant;
  assign busy        = (r_state != IDLE);
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Randomized and directed bench for axis_uart_tx_arbiter against a cycle-level ownership model.
module tb_axis_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N*W-1:0] s_data = '0;
  logic [N-1:0]   s_valid = '0;
  logic [N-1:0]   s_last = '0;
  logic [N-1:0]   s_ready;
  logic [W-1:0]   m_data;
  logic           m_valid, m_last;
  logic           m_ready = 1'b1;
  logic [1:0]     grant_id;
  logic           busy, timeout_err;

  always #5 clk = ~clk;

  axis_uart_tx_arbiter #(.WIDTH(W), .NUM_SRC(N), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_data  (s_data),
    .s_axis_valid (s_valid),
    .s_axis_last  (s_last),
    .s_axis_ready (s_ready),
    .m_axis_data  (m_data),
    .m_axis_valid (m_valid),
    .m_axis_last  (m_last),
    .m_axis_ready (m_ready),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  typedef struct packed {logic [7:0] d; logic l;} beat_t;

  beat_t      src_q[N][$];
  logic [N-1:0] hold = '0;
  int         hold_cnt[N];
  int         total = 0, bad = 0;
  // model: ph 0 = no owner, 1 = header beat, 2 = owner streaming
  int         ph, own, ptr, stall, last_gnt, to_cnt, pushed;
  bit         exp_to, prev_busy;
  int         log_gnt[$];
  int         out_log[$];
  int         tag_log[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int at(int q[$], int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += src_q[i].size();
    return s;
  endfunction

  task automatic push_byte(int src, logic [7:0] d, logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    src_q[src].push_back(b);
    pushed++;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        s_valid[i]         = 1'b1;
        s_data[i*W +: W]   = src_q[i][0].d;
        s_last[i]          = src_q[i][0].l;
      end else begin
        s_valid[i]         = 1'b0;
        s_data[i*W +: W]   = 8'($urandom);
        s_last[i]          = 1'($urandom);
      end
    end
  endtask

  task automatic model_check(output int acc);
    logic [N-1:0] er;
    logic [7:0]   ed;
    logic         ev, el;
    int           nph, w;
    bit           nto;
    acc = -1; er = '0; ed = '0; ev = 1'b0; el = 1'b0; nph = ph; nto = 1'b0;
    check("timeout_err", timeout_err, exp_to);
    if (timeout_err) to_cnt++;
    check("grant_id", grant_id, last_gnt);
    check("busy", busy, ph != 0);
    if (busy && !prev_busy) log_gnt.push_back(int'(grant_id));
    prev_busy = busy;
    case (ph)
      0: begin
        if (s_valid != '0) begin
          w = -1;
          for (int k = 0; k < N; k++)
            if (w < 0 && s_valid[(ptr + k) % N]) w = (ptr + k) % N;
          own = w; last_gnt = w; ptr = (w + 1) % N; stall = 0;
`ifdef AXIS_ARB_SRC_TAG_EN
          nph = 1;
`else
          nph = 2;
`endif
        end
      end
      1: begin
        ev = 1'b1;
        ed = 8'hA0 | 8'(own);
        if (m_ready) begin
          tag_log.push_back((own << 16) | int'(m_data));
          nph = 2;
        end
      end
      default: begin
        ev = s_valid[own];
        ed = s_data[own*W +: W];
        el = s_last[own];
        er[own] = m_ready;
        if (ev && m_ready) begin
          acc = own;
          out_log.push_back((own << 16) | (int'(m_last) << 8) | int'(m_data));
          stall = 0;
          if (el) nph = 0;
        end else if (!ev) begin
          stall++;
          if (stall == TO) begin
            nph = 0; nto = 1'b1; stall = 0;
          end
        end else begin
          stall = 0;
        end
      end
    endcase
    check("m_valid", m_valid, ev);
    check("m_last", m_last, el);
    check("m_data", m_data, ed);
    check("s_ready", s_ready, er);
    ph = nph;
    exp_to = nto;
  endtask

  task automatic cycle();
    int acc;
    drive_inputs();
    #1;
    model_check(acc);
    @(posedge clk);
    if (acc >= 0) void'(src_q[acc].pop_front());
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      hold_cnt[i] = 0;
    end
    hold = '0; m_ready = 1'b1;
    drive_inputs();
    ph = 0; own = 0; ptr = 0; stall = 0; last_gnt = 0; exp_to = 1'b0;
    prev_busy = 1'b0; to_cnt = 0; pushed = 0;
    log_gnt.delete(); out_log.delete(); tag_log.delete();
    @(negedge clk);
    #1;
    check("rst_out", {busy, timeout_err, m_valid, m_last, m_data, s_ready, grant_id}, '0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_quiet(int maxc);
    int n = 0;
    while ((pending() != 0 || ph != 0) && n < maxc) begin
      cycle();
      n++;
    end
    cycle();
    check("drain", pending() + ph, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench time limit");
  end

  initial begin
    // single source
    do_reset();
    push_byte(1, 8'h11, 1'b0); push_byte(1, 8'h22, 1'b0); push_byte(1, 8'h33, 1'b1);
    run_quiet(50);
    check("single_gnt", at(log_gnt, 0), 1);
    check("single_b0", at(out_log, 0), 32'h10011);
    check("single_b1", at(out_log, 1), 32'h10022);
    check("single_b2", at(out_log, 2), 32'h10133);

    // contention from reset
    do_reset();
    for (int i = 0; i < N; i++) begin
      push_byte(i, 8'((i << 4) | 1), 1'b0);
      push_byte(i, 8'((i << 4) | 2), 1'b1);
    end
    run_quiet(100);
    for (int i = 0; i < N; i++) begin
      check("cont_gnt", at(log_gnt, i), i);
      check("cont_b0", at(out_log, 2*i), (i << 16) | (i << 4) | 1);
      check("cont_b1", at(out_log, 2*i + 1), (i << 16) | 32'h100 | (i << 4) | 2);
    end

    // rotation
    do_reset();
    push_byte(2, 8'h2A, 1'b1);
    run_quiet(20);
    push_byte(0, 8'h0A, 1'b1); push_byte(3, 8'h3A, 1'b1);
    run_quiet(40);
    check("rot_0", at(log_gnt, 0), 2);
    check("rot_1", at(log_gnt, 1), 3);
    check("rot_2", at(log_gnt, 2), 0);

    // backpressure
    do_reset();
    for (int k = 0; k < 4; k++) push_byte(0, 8'(8'hB0 + k), k == 3);
    cycle();
`ifdef AXIS_ARB_SRC_TAG_EN
    cycle();
`endif
    m_ready = 1'b1; cycle();
    m_ready = 1'b0; cycle();
    m_ready = 1'b0; cycle();
    m_ready = 1'b1; cycle();
    run_quiet(20);
    check("bp_n", out_log.size(), 4);
    for (int k = 0; k < 4; k++)
      check("bp_b", at(out_log, k), ((k == 3) ? 32'h100 : 32'h0) | (32'hB0 + k));
    check("bp_to", to_cnt, 0);

    // watchdog
    do_reset();
    push_byte(1, 8'h77, 1'b0);
    repeat (4) cycle();
    push_byte(2, 8'h2B, 1'b0); push_byte(2, 8'h2C, 1'b1);
    run_quiet(60);
    check("wd_pulses", to_cnt, 1);
    check("wd_gnt0", at(log_gnt, 0), 1);
    check("wd_gnt1", at(log_gnt, 1), 2);
    check("wd_b0", at(out_log, 0), 32'h10077);
    check("wd_b1", at(out_log, 1), 32'h2002B);
    check("wd_b2", at(out_log, 2), 32'h2012C);

`ifdef AXIS_ARB_SRC_TAG_EN
    do_reset();
    push_byte(3, 8'h55, 1'b1);
    run_quiet(20);
    check("tag_hdr", at(tag_log, 0), 32'h300A3);
    check("tag_pay", at(out_log, 0), 32'h30155);
`endif

    // reset mid-packet, then priority restarts at source 0
    do_reset();
    for (int k = 0; k < 4; k++) push_byte(2, 8'(8'hC0 + k), k == 3);
    repeat (3) cycle();
    #2 rst = 1'b0;
    #1 check("midrst_out", {busy, timeout_err, m_valid, m_last, m_data, s_ready, grant_id}, '0);
    do_reset();
    push_byte(3, 8'h3D, 1'b1); push_byte(1, 8'h1D, 1'b1);
    run_quiet(40);
    check("midrst_g0", at(log_gnt, 0), 1);
    check("midrst_g1", at(log_gnt, 1), 3);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() < 3 && $urandom % 4 == 0) begin
          int len;
          len = $urandom_range(4, 1);
          for (int k = 0; k < len; k++) push_byte(i, 8'($urandom), k == len - 1);
        end
        if (hold_cnt[i] > 0) begin
          hold_cnt[i]--;
          hold[i] = 1'b1;
        end else if ($urandom % 64 == 0) begin
          hold_cnt[i] = $urandom_range(12, 1);
          hold[i] = 1'b1;
        end else begin
          hold[i] = ($urandom % 8 == 0);
        end
      end
      m_ready = ($urandom % 4 != 0);
      cycle();
    end
    hold = '0;
    m_ready = 1'b1;
    run_quiet(2000);
    check("rand_bytes", out_log.size(), pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
